// File: rtl/shiftreg_univ.sv
// Universal WIDTH-bit register: hold / shift / rotate / load / clear under a 3-bit mode,
// with a saturating shift counter and full flag for serial-to-parallel use.
module shiftreg_univ #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CW          = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    cnt,
  output logic             full
);

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_SHL   = 3'b001,
    M_SHR   = 3'b010,
    M_ROL   = 3'b011,
    M_ROR   = 3'b100,
    M_LOAD  = 3'b101,
    M_CLEAR = 3'b110,
    M_RSVD  = 3'b111
  } mode_e;

  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH-1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q    <= RESET_VALUE;
      cnt  <= '0;
      full <= 1'b0;
    end else if (en) begin
      case (mode_e'(mode))
        M_SHL: begin
          q    <= {q[WIDTH-2:0], sin_r};
          cnt  <= (cnt == CNT_MAX) ? CNT_MAX : cnt + CW'(1);
          // full rises on the edge that carries cnt into WIDTH and stays set
          full <= full | (cnt == CNT_LAST);
        end
        M_SHR: begin
          q    <= {sin_l, q[WIDTH-1:1]};
          cnt  <= (cnt == CNT_MAX) ? CNT_MAX : cnt + CW'(1);
          full <= full | (cnt == CNT_LAST);
        end
        M_ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]};
        M_ROR: q <= {q[0], q[WIDTH-1:1]};
        M_LOAD: begin
          q    <= d;
          cnt  <= '0;
          full <= 1'b0;
        end
        M_CLEAR: begin
          q    <= '0;
          cnt  <= '0;
          full <= 1'b0;
        end
        default: ;  // hold and reserved code
      endcase
    end
  end

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

endmodule

// File: tb/tb_shiftreg_univ.sv
// Scoreboard bench for shiftreg_univ: an 8-bit instance and a 4-bit instance
// (RESET_VALUE 4'hA) share one stimulus bus; each step names which one it checks.
module tb_shiftreg_univ;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [2:0] mode = 3'b000;
  logic       sin_l = 1'b0;
  logic       sin_r = 1'b0;
  logic [7:0] d = 8'h00;

  logic [7:0] q8;
  logic       sout_l8, sout_r8, full8;
  logic [3:0] cnt8;
  logic [3:0] q4;
  logic       sout_l4, sout_r4, full4;
  logic [2:0] cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       w;
    logic [7:0] q;
    logic [3:0] cnt;
    logic       full;
    logic       sl;
    logic       sr;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];

  shiftreg_univ #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sin_l(sin_l), .sin_r(sin_r),
    .d(d), .q(q8), .sout_l(sout_l8), .sout_r(sout_r8), .cnt(cnt8), .full(full8)
  );

  shiftreg_univ #(.WIDTH(4), .RESET_VALUE(4'hA)) dut4 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sin_l(sin_l), .sin_r(sin_r),
    .d(d[3:0]), .q(q4), .sout_l(sout_l4), .sout_r(sout_r4), .cnt(cnt4), .full(full4)
  );

  always #5 clk = ~clk;

  function automatic rec_t sample(input logic w);
    rec_t o;
    o.w = w;
    if (w) begin
      o.q = {4'h0, q4}; o.cnt = {1'b0, cnt4}; o.full = full4; o.sl = sout_l4; o.sr = sout_r4;
    end else begin
      o.q = q8; o.cnt = cnt8; o.full = full8; o.sl = sout_l8; o.sr = sout_r8;
    end
    return o;
  endfunction

  // Drive one cycle; push the expected state, then capture the DUT state after the edge.
  task automatic step(input logic e, input logic [2:0] m, input logic [7:0] dd,
                      input logic sl, input logic sr, input logic w,
                      input logic [7:0] eq, input logic [3:0] ec, input logic ef);
    rec_t x;
    @(negedge clk);
    en = e; mode = m; d = dd; sin_l = sl; sin_r = sr;
    x.w = w; x.q = eq; x.cnt = ec; x.full = ef;
    x.sl = w ? eq[3] : eq[7];
    x.sr = eq[0];
    exp_q.push_back(x);
    @(posedge clk); #1;
    obs_q.push_back(sample(w));
  endtask

  task automatic test_reset();
    rec_t e, o;
    step(1, 3'b101, 8'hA5, 0, 0, 0, 8'hA5, 0, 0);
    #3 reset = 1'b1;
    #1;
    n_tests++;
    if (q8 !== 8'h00 || cnt8 !== 4'd0 || full8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async8: got q=%h cnt=%0d full=%b expected q=00 cnt=0 full=0", q8, cnt8, full8);
    end
    n_tests++;
    if (q4 !== 4'hA || cnt4 !== 3'd0 || full4 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async4: got q=%h cnt=%0d full=%b expected q=a cnt=0 full=0", q4, cnt4, full4);
    end
    @(posedge clk); #3 reset = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 3'b101, 8'hFF, 1, 1, 0, 8'h00, 0, 0);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset: got q=%h cnt=%0d full=%b sl=%b sr=%b expected q=%h cnt=%0d full=%b sl=%b sr=%b",
                 o.q, o.cnt, o.full, o.sl, o.sr, e.q, e.cnt, e.full, e.sl, e.sr);
      end
    end
  endtask

  task automatic test_load_rotate();
    rec_t e, o;
    step(1, 3'b101, 8'h81, 0, 0, 0, 8'h81, 0, 0);
    step(1, 3'b011, 8'h00, 0, 0, 0, 8'h03, 0, 0);
    step(1, 3'b100, 8'h00, 0, 0, 0, 8'h81, 0, 0);
    step(1, 3'b100, 8'h00, 0, 0, 0, 8'hC0, 0, 0);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL load_rotate: got q=%h cnt=%0d full=%b sl=%b sr=%b expected q=%h cnt=%0d full=%b sl=%b sr=%b",
                 o.q, o.cnt, o.full, o.sl, o.sr, e.q, e.cnt, e.full, e.sl, e.sr);
      end
    end
  endtask

  task automatic test_serial_in();
    rec_t e, o;
    logic [7:0] bits = 8'b1011_0010;
    logic [7:0] qs[8] = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h59, 8'hB2};
    step(1, 3'b110, 8'hFF, 0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 8; i++)
      step(1, 3'b001, 8'h00, 0, bits[7-i], 0, qs[i], 4'(i+1), (i == 7));
    step(1, 3'b001, 8'h00, 0, 1, 0, 8'h65, 8, 1);
    // a right shift after saturation: direction is not tracked, cnt stays at 8
    step(1, 3'b010, 8'h00, 1, 0, 0, 8'hB2, 8, 1);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL serial_in: got q=%h cnt=%0d full=%b sl=%b sr=%b expected q=%h cnt=%0d full=%b sl=%b sr=%b",
                 o.q, o.cnt, o.full, o.sl, o.sr, e.q, e.cnt, e.full, e.sl, e.sr);
      end
    end
  endtask

  task automatic test_shift_right();
    rec_t e, o;
    logic [7:0] qs[4] = '{8'h78, 8'h3C, 8'h1E, 8'h0F};
    step(1, 3'b101, 8'hF0, 0, 0, 0, 8'hF0, 0, 0);
    for (int i = 0; i < 4; i++)
      step(1, 3'b010, 8'h00, 0, 1, 0, qs[i], 4'(i+1), 0);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL shift_right: got q=%h cnt=%0d full=%b sl=%b sr=%b expected q=%h cnt=%0d full=%b sl=%b sr=%b",
                 o.q, o.cnt, o.full, o.sl, o.sr, e.q, e.cnt, e.full, e.sl, e.sr);
      end
    end
  endtask

  task automatic test_enable_reserved();
    rec_t e, o;
    step(1, 3'b101, 8'h78, 0, 0, 0, 8'h78, 0, 0);
    step(1, 3'b010, 8'h00, 0, 0, 0, 8'h3C, 1, 0);
    for (int m = 0; m < 8; m++)
      step(0, 3'(m), 8'hFF, 1, 1, 0, 8'h3C, 1, 0);
    step(1, 3'b111, 8'hFF, 1, 1, 0, 8'h3C, 1, 0);
    step(1, 3'b000, 8'hFF, 1, 1, 0, 8'h3C, 1, 0);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL enable_reserved: got q=%h cnt=%0d full=%b sl=%b sr=%b expected q=%h cnt=%0d full=%b sl=%b sr=%b",
                 o.q, o.cnt, o.full, o.sl, o.sr, e.q, e.cnt, e.full, e.sl, e.sr);
      end
    end
  endtask

  task automatic test_width4();
    rec_t e, o;
    @(negedge clk); reset = 1'b1; en = 1'b0;
    @(negedge clk); reset = 1'b0;
    step(0, 3'b000, 8'h00, 0, 0, 1, 8'h0A, 0, 0);
    step(1, 3'b110, 8'h00, 0, 0, 1, 8'h00, 0, 0);
    step(1, 3'b001, 8'h00, 0, 1, 1, 8'h01, 1, 0);
    step(1, 3'b001, 8'h00, 0, 1, 1, 8'h03, 2, 0);
    step(1, 3'b001, 8'h00, 0, 1, 1, 8'h07, 3, 0);
    step(1, 3'b001, 8'h00, 0, 1, 1, 8'h0F, 4, 1);
    step(1, 3'b001, 8'h00, 0, 0, 1, 8'h0E, 4, 1);
    step(1, 3'b101, 8'h05, 0, 0, 1, 8'h05, 0, 0);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL width4: got q=%h cnt=%0d full=%b sl=%b sr=%b expected q=%h cnt=%0d full=%b sl=%b sr=%b",
                 o.q, o.cnt, o.full, o.sl, o.sr, e.q, e.cnt, e.full, e.sl, e.sr);
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    test_reset();
    test_load_rotate();
    test_serial_in();
    test_shift_right();
    test_enable_reserved();
    test_width4();
    n_tests++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got exp=%0d obs=%0d left expected 0", exp_q.size(), obs_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
